// File: rtl/fetch_unit_pkg.sv
// Shared CPU16 definitions for the instruction-fetch stage: word width,
// instruction length, default vectors, the NOP word, the next-PC selection
// enum and the branch-target helper.
package fetch_unit_pkg;

  localparam int WORD_W = 16;

  // Every instruction is one 16-bit word, i.e. two bytes of address space.
  localparam logic [WORD_W-1:0] INSTR_LEN = 16'd2;

  localparam logic [WORD_W-1:0] DEF_NOP_INSTR    = 16'h0000;
  localparam logic [WORD_W-1:0] DEF_RESET_VECTOR = 16'h0000;
  localparam logic [WORD_W-1:0] DEF_TRAP_VECTOR  = 16'h0002;

  // Clears bit 0 of a redirect target when misalignment is not trapped.
  localparam logic [WORD_W-1:0] ALIGN_MASK = 16'hFFFE;

  // What the PC/IF-ID registers do on the next edge.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,  // PC+2, IF/ID captures the fetched word
    SEL_HOLD   = 2'd1,  // stall: everything holds
    SEL_BRANCH = 2'd2,  // taken branch: redirect and bubble
    SEL_JUMP   = 2'd3   // absolute jump: redirect and bubble
  } pc_sel_e;

  // Branch offset is a signed word count relative to the instruction after
  // the branch; the shift turns words into bytes. Wraps modulo 2^16.
  function automatic logic [WORD_W-1:0] branch_target(
    input logic [WORD_W-1:0] base_pc,
    input logic [7:0]        offset
  );
    return base_pc + INSTR_LEN + {{7{offset[7]}}, offset, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for the fetch stage.
// Priority is Jump > Branch > Stall > sequential. A redirect always wins over
// a stall because the stalled instruction is being squashed anyway.
// Optional feature macro: MISALIGN_TRAP_EN (odd redirect target goes to
// TRAP_VECTOR and raises misalign); otherwise bit 0 of the target is cleared.
module pc_next_sel
  import fetch_unit_pkg::*;
`ifdef MISALIGN_TRAP_EN
#(
  parameter logic [WORD_W-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR
)
`endif
(
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] ifid_pc,
  input  logic              stall,
  input  logic              branch,
  input  logic [7:0]        branch_offset,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_target,
  output logic [WORD_W-1:0] next_pc,
  output pc_sel_e           sel
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  logic [WORD_W-1:0] redirect_tgt;

  // Select next PC and the register action by fixed priority.
  always_comb begin
    sel          = SEL_SEQ;
    next_pc      = pc + INSTR_LEN;
    redirect_tgt = jump ? jump_target : branch_target(ifid_pc, branch_offset);
`ifdef MISALIGN_TRAP_EN
    misalign     = 1'b0;
`endif
    if (jump || branch) begin
      sel = jump ? SEL_JUMP : SEL_BRANCH;
`ifdef MISALIGN_TRAP_EN
      if (redirect_tgt[0]) begin
        next_pc  = TRAP_VECTOR;
        misalign = 1'b1;
      end else begin
        next_pc  = redirect_tgt;
      end
`else
      next_pc = redirect_tgt & ALIGN_MASK;
`endif
    end else if (stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit CPU. Owns the PC, drives
// it to instruction memory (combinational read) and registers {PC, word}
// into IF/ID. Stall holds everything; Jump/Branch redirect with one bubble.
// Optional feature macro: MISALIGN_TRAP_EN (trap on odd redirect target and
// pulse Misalign for one cycle); when undefined Misalign is tied low.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
`ifdef MISALIGN_TRAP_EN
  parameter logic [WORD_W-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
`endif
  parameter logic [WORD_W-1:0] NOP_INSTR    = DEF_NOP_INSTR
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Stall,
  input  logic              Branch,
  input  logic [7:0]        BranchOffset,
  input  logic              Jump,
  input  logic [WORD_W-1:0] JumpTarget,
  input  logic [WORD_W-1:0] Instruction,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] IFID_PC,
  output logic [WORD_W-1:0] IFID_Instr,
  output logic              IFID_Valid,
  output logic              Misalign
);

  logic [WORD_W-1:0] next_pc;
  pc_sel_e           sel;
`ifdef MISALIGN_TRAP_EN
  logic              misalign_now;
`endif

  pc_next_sel
`ifdef MISALIGN_TRAP_EN
  #(
    .TRAP_VECTOR (TRAP_VECTOR)
  )
`endif
  u_pc_next_sel (
    .pc            (PC),
    .ifid_pc       (IFID_PC),
    .stall         (Stall),
    .branch        (Branch),
    .branch_offset (BranchOffset),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .next_pc       (next_pc),
    .sel           (sel)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign      (misalign_now)
`endif
  );

  // PC and IF/ID register: sequential capture, hold on stall, bubble on redirect.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      PC         <= RESET_VECTOR;
      IFID_PC    <= '0;
      IFID_Instr <= NOP_INSTR;
      IFID_Valid <= 1'b0;
    end else begin
      case (sel)
        SEL_SEQ: begin
          PC         <= next_pc;
          IFID_PC    <= PC;
          IFID_Instr <= Instruction;
          IFID_Valid <= 1'b1;
        end
        SEL_BRANCH, SEL_JUMP: begin
          // IFID_PC is left alone: a bubble carries no address.
          PC         <= next_pc;
          IFID_Instr <= NOP_INSTR;
          IFID_Valid <= 1'b0;
        end
        default: begin
          // SEL_HOLD: the stalled instruction and its PC stay put.
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle pulse for the edge that took the trap.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Misalign <= 1'b0;
    end else begin
      Misalign <= misalign_now;
    end
  end
`else
  assign Misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized control
// traffic checked against a behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam logic [15:0] RESET_VECTOR = 16'h0000;
  localparam logic [15:0] TRAP_VECTOR  = 16'h0002;
  localparam logic [15:0] NOP_INSTR    = 16'h0000;

  // Clock/reset and DUT signals
  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Stall = 1'b0;
  logic        Branch = 1'b0;
  logic [7:0]  BranchOffset = 8'h00;
  logic        Jump = 1'b0;
  logic [15:0] JumpTarget = 16'h0000;
  logic [15:0] Instruction;
  logic [15:0] PC;
  logic [15:0] IFID_PC;
  logic [15:0] IFID_Instr;
  logic        IFID_Valid;
  logic        Misalign;

  always #5 Clock = ~Clock;

  // Instruction memory: 256 random words, combinational read.
  logic [15:0] imem [0:255];
  assign Instruction = imem[PC[8:1]];

  fetch_unit dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Stall        (Stall),
    .Branch       (Branch),
    .BranchOffset (BranchOffset),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Instruction  (Instruction),
    .PC           (PC),
    .IFID_PC      (IFID_PC),
    .IFID_Instr   (IFID_Instr),
    .IFID_Valid   (IFID_Valid),
    .Misalign     (Misalign)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_pc, m_ifid_pc, m_ifid_instr;
  logic        m_valid, m_mis;

  task automatic model_reset();
    m_pc = RESET_VECTOR; m_ifid_pc = 16'h0000; m_ifid_instr = NOP_INSTR;
    m_valid = 1'b0; m_mis = 1'b0;
  endtask

  // One clock edge of the fetch stage as described by its rules.
  task automatic model_step(input logic st, input logic br, input logic [7:0] off,
                            input logic jp, input logic [15:0] jt);
    int          t;
    logic [15:0] tgt;
    m_mis = 1'b0;
    if (jp || br) begin
      if (jp) tgt = jt;
      else begin
        t   = int'(m_ifid_pc) + 2 + 2 * int'($signed(off));
        tgt = t[15:0];
      end
`ifdef MISALIGN_TRAP_EN
      if (tgt[0]) begin m_pc = TRAP_VECTOR; m_mis = 1'b1; end
      else m_pc = tgt;
`else
      m_pc = tgt - (tgt % 16'd2);
`endif
      m_valid = 1'b0;
      m_ifid_instr = NOP_INSTR;
    end else if (!st) begin
      m_ifid_pc    = m_pc;
      m_ifid_instr = imem[m_pc[8:1]];
      m_valid      = 1'b1;
      t            = int'(m_pc) + 2;
      m_pc         = t[15:0];
    end
  endtask

  // Driver: apply controls for one edge, advance the model, sample 1ns later.
  task automatic apply(input logic st, input logic br, input logic [7:0] off,
                       input logic jp, input logic [15:0] jt);
    Stall = st; Branch = br; BranchOffset = off; Jump = jp; JumpTarget = jt;
    @(posedge Clock);
    model_step(st, br, off, jp, jt);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    Stall = 0; Branch = 0; BranchOffset = 0; Jump = 0; JumpTarget = 0;
    @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #1;
    checks++;
    if (PC !== RESET_VECTOR || IFID_PC !== 16'h0000 || IFID_Instr !== NOP_INSTR ||
        IFID_Valid !== 1'b0 || Misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got pc=%h ifid_pc=%h instr=%h v=%b mis=%b exp pc=%h 0000 %h 0 0",
               PC, IFID_PC, IFID_Instr, IFID_Valid, Misalign, RESET_VECTOR, NOP_INSTR);
    end
    @(posedge Clock); @(posedge Clock); #1;
    checks++;
    if (PC !== RESET_VECTOR || IFID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got pc=%h v=%b exp pc=%h v=0", PC, IFID_Valid, RESET_VECTOR);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      apply(0, 0, 8'h00, 0, 16'h0000);
      checks++;
      if (PC !== 16'(2 * i) || IFID_PC !== 16'(2 * (i - 1)) || IFID_Valid !== 1'b1 ||
          IFID_Instr !== imem[i - 1]) begin
        errors++;
        $display("FAIL seq_%0d: got pc=%h ifid_pc=%h v=%b instr=%h exp pc=%h ifid_pc=%h v=1 instr=%h",
                 i, PC, IFID_PC, IFID_Valid, IFID_Instr, 16'(2 * i), 16'(2 * (i - 1)), imem[i - 1]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 6; i++) apply(0, 0, 8'h00, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 8'h00, 0, 16'h0000);
      checks++;
      if (PC !== 16'h000C || IFID_PC !== 16'h000A || IFID_Valid !== 1'b1 || IFID_Instr !== imem[5]) begin
        errors++;
        $display("FAIL stall_hold_%0d: got pc=%h ifid_pc=%h v=%b instr=%h exp pc=000c ifid_pc=000a v=1 instr=%h",
                 i, PC, IFID_PC, IFID_Valid, IFID_Instr, imem[5]);
      end
    end
    apply(0, 0, 8'h00, 0, 16'h0000);
    checks++;
    if (PC !== 16'h000E || IFID_PC !== 16'h000C || IFID_Instr !== imem[6] || IFID_Valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got pc=%h ifid_pc=%h instr=%h v=%b exp pc=000e ifid_pc=000c instr=%h v=1",
               PC, IFID_PC, IFID_Instr, IFID_Valid, imem[6]);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 9; i++) apply(0, 0, 8'h00, 0, 16'h0000);
    checks++;
    if (IFID_PC !== 16'h0010) begin
      errors++;
      $display("FAIL branch_setup: got ifid_pc=%h exp 0010", IFID_PC);
    end
    apply(0, 1, 8'hFC, 0, 16'h0000);
    checks++;
    if (PC !== 16'h000A || IFID_Valid !== 1'b0 || IFID_Instr !== NOP_INSTR || IFID_PC !== 16'h0010) begin
      errors++;
      $display("FAIL branch_back: got pc=%h v=%b instr=%h ifid_pc=%h exp pc=000a v=0 instr=%h ifid_pc=0010",
               PC, IFID_Valid, IFID_Instr, IFID_PC, NOP_INSTR);
    end
    apply(0, 0, 8'h00, 0, 16'h0000);
    checks++;
    if (PC !== 16'h000C || IFID_PC !== 16'h000A || IFID_Valid !== 1'b1 || IFID_Instr !== imem[5]) begin
      errors++;
      $display("FAIL branch_resume: got pc=%h ifid_pc=%h v=%b instr=%h exp pc=000c ifid_pc=000a v=1 instr=%h",
               PC, IFID_PC, IFID_Valid, IFID_Instr, imem[5]);
    end
  endtask

  task automatic test_jump_priority();
    logic [15:0] held_ifid_pc;
    held_ifid_pc = IFID_PC;
    apply(1, 1, 8'($urandom_range(0, 255)), 1, 16'h0100);
    checks++;
    if (PC !== 16'h0100 || IFID_Valid !== 1'b0 || IFID_Instr !== NOP_INSTR || IFID_PC !== held_ifid_pc) begin
      errors++;
      $display("FAIL jump_priority: got pc=%h v=%b instr=%h ifid_pc=%h exp pc=0100 v=0 instr=%h ifid_pc=%h",
               PC, IFID_Valid, IFID_Instr, IFID_PC, NOP_INSTR, held_ifid_pc);
    end
    apply(0, 0, 8'h00, 0, 16'h0000);
    checks++;
    if (PC !== 16'h0102 || IFID_PC !== 16'h0100 || IFID_Instr !== imem[128] || IFID_Valid !== 1'b1) begin
      errors++;
      $display("FAIL jump_resume: got pc=%h ifid_pc=%h instr=%h v=%b exp pc=0102 ifid_pc=0100 instr=%h v=1",
               PC, IFID_PC, IFID_Instr, IFID_Valid, imem[128]);
    end
  endtask

  task automatic test_wrap();
    apply(0, 0, 8'h00, 1, 16'hFFFE);
    apply(0, 0, 8'h00, 0, 16'h0000);
    checks++;
    if (PC !== 16'h0000 || IFID_PC !== 16'hFFFE || IFID_Instr !== imem[255]) begin
      errors++;
      $display("FAIL pc_wrap: got pc=%h ifid_pc=%h instr=%h exp pc=0000 ifid_pc=fffe instr=%h",
               PC, IFID_PC, IFID_Instr, imem[255]);
    end
  endtask

  task automatic test_misalign();
    apply(0, 0, 8'h00, 1, 16'h0101);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (PC !== TRAP_VECTOR || Misalign !== 1'b1 || IFID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_trap: got pc=%h mis=%b v=%b exp pc=%h mis=1 v=0", PC, Misalign, IFID_Valid, TRAP_VECTOR);
    end
    apply(0, 0, 8'h00, 0, 16'h0000);
    checks++;
    if (Misalign !== 1'b0 || PC !== TRAP_VECTOR + 16'd2) begin
      errors++;
      $display("FAIL misalign_pulse: got mis=%b pc=%h exp mis=0 pc=%h", Misalign, PC, TRAP_VECTOR + 16'd2);
    end
`else
    checks++;
    if (PC !== 16'h0100 || Misalign !== 1'b0 || IFID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_force: got pc=%h mis=%b v=%b exp pc=0100 mis=0 v=0", PC, Misalign, IFID_Valid);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) apply(0, 0, 8'h00, 0, 16'h0000);
    apply(1, 0, 8'h00, 0, 16'h0000);
    #1;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (PC !== RESET_VECTOR || IFID_PC !== 16'h0000 || IFID_Instr !== NOP_INSTR ||
        IFID_Valid !== 1'b0 || Misalign !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pc=%h ifid_pc=%h instr=%h v=%b mis=%b exp pc=%h 0000 %h 0 0",
               PC, IFID_PC, IFID_Instr, IFID_Valid, Misalign, RESET_VECTOR, NOP_INSTR);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    Stall = 1'b0;
    model_reset();
    apply(0, 0, 8'h00, 0, 16'h0000);
    checks++;
    if (PC !== 16'h0002 || IFID_PC !== RESET_VECTOR || IFID_Valid !== 1'b1 || IFID_Instr !== imem[0]) begin
      errors++;
      $display("FAIL first_fetch: got pc=%h ifid_pc=%h v=%b instr=%h exp pc=0002 ifid_pc=%h v=1 instr=%h",
               PC, IFID_PC, IFID_Valid, IFID_Instr, RESET_VECTOR, imem[0]);
    end
  endtask

  task automatic test_random();
    logic        st, br, jp;
    logic [7:0]  off;
    logic [15:0] jt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      jp  = ($urandom_range(0, 9) == 0);
      off = 8'($urandom_range(0, 255));
      jt  = 16'($urandom_range(0, 65535));
      apply(st, br, off, jp, jt);
      checks++;
      if (PC !== m_pc || IFID_PC !== m_ifid_pc || IFID_Instr !== m_ifid_instr ||
          IFID_Valid !== m_valid || Misalign !== m_mis) begin
        errors++;
        $display("FAIL random_%0d: got pc=%h ifid_pc=%h instr=%h v=%b mis=%b exp pc=%h ifid_pc=%h instr=%h v=%b mis=%b",
                 n, PC, IFID_PC, IFID_Instr, IFID_Valid, Misalign,
                 m_pc, m_ifid_pc, m_ifid_instr, m_valid, m_mis);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom_range(0, 65535));
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_misalign();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
